// File: rtl/pix_pkg.sv
// Shared widths and arbiter state encoding for the pixel-path ZBT memory interface.
package pix_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int CNT_W  = 3;

  typedef enum logic [0:0] {
    RD_PRI   = 1'b0,
    WR_DRAIN = 1'b1
  } arb_state_t;
endpackage

// File: rtl/zbt_wr_fifo.sv
// Synchronous write buffer holding {address, data} pairs; count, full and empty are registered-derived.
module zbt_wr_fifo
  import pix_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din_addr,
  input  logic [DATA_W-1:0] din_data,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= {din_addr, din_data};
  end

  assign {dout_addr, dout_data} = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == CNT_W'(0));
endmodule

// File: rtl/zbt_arbiter.sv
// Single-bank ZBT arbiter: display reads have priority, buffered writes drain in bounded bursts.
module zbt_arbiter
  import pix_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2,
  parameter int DRAIN_TH   = 3,
  parameter int DRAIN_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic              zbt_we,
  output logic [DATA_W-1:0] zbt_wdata,
  input  logic [DATA_W-1:0] zbt_rdata,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              ovf
);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [DW-1:0]     drain_cnt;
  logic [DW-1:0]     drain_nxt;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  logic              drop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [RD_LAT:0]   rd_pipe;

  zbt_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din_addr  (wr_addr),
    .din_data  (wr_data),
    .dout_addr (head_addr),
    .dout_data (head_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    rd_gnt    = 1'b0;
    pop       = 1'b0;
    if (!reset) begin
      state_nxt = RD_PRI;
      drain_nxt = '0;
    end else begin
      case (state)
        RD_PRI: begin
          drain_nxt = '0;
          if (rd_req) begin
            rd_gnt = 1'b1;
          end else begin
            pop = ~empty;
          end
          if (fifo_count >= CNT_W'(DRAIN_TH)) begin
            state_nxt = WR_DRAIN;
          end else begin
            state_nxt = RD_PRI;
          end
        end
        WR_DRAIN: begin
          pop = ~empty;
          // Occupancy after this cycle is zero only if at most one entry remains and nothing arrives.
          if ((!wr_en && fifo_count <= CNT_W'(1)) || drain_cnt == DW'(DRAIN_MAX - 1)) begin
            state_nxt = RD_PRI;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain_cnt + DW'(1);
          end
        end
        default: begin
          state_nxt = RD_PRI;
          drain_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RD_PRI;
      drain_cnt <= '0;
      ovf       <= 1'b0;
      zbt_we    <= 1'b0;
      zbt_addr  <= '0;
      zbt_wdata <= '0;
      rd_pipe   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      zbt_we    <= pop;
      if (rd_gnt) begin
        zbt_addr <= rd_addr;
      end else if (pop) begin
        zbt_addr  <= head_addr;
        zbt_wdata <= head_data;
      end
      // rd_pipe[k] marks a read whose address went out k+1 cycles ago.
      rd_pipe  <= {rd_pipe[RD_LAT-1:0], rd_gnt};
      rd_valid <= rd_pipe[RD_LAT];
      if (rd_pipe[RD_LAT]) rd_data <= zbt_rdata;
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end
endmodule
